delay_timer: RTL

DELAY_TIMER -- requirements
Module: delay_timer

---
 rtl/delay_timer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/delay_timer.sv
// delay_timer
//   Counts a programmable number of time units, each PRESCALE clocks long
//   (PRESCALE = UNIT_COUNTS_US * CLK_MHZ). A run can be cancelled by dropping
//   delay_enable_in.
//
// Ports
//   clock_in              : single clock, all logic on its rising edge
//   reset_in              : synchronous, active-high reset
//   delay_enable_in       : permits a start and keeps a running delay alive
//   delay_start_strobe_in : start request, level-sampled
//   delay_value_in        : delay length in units (0 behaves as a 1-cycle delay)
//   delay_busy_out        : high while a delay is running
//   delay_done_out        : one-cycle pulse on normal completion
//   delay_abort_out       : one-cycle pulse when a running delay is cancelled
//
// Start handshake: a start is taken on a rising edge where the strobe is 1,
// enable is 1 and the timer is armed. The timer becomes armed on any edge
// that samples the strobe low and disarms when a start is taken, so a strobe
// held high produces exactly one run. Starts are only taken in IDLE or DONE.
module delay_timer #(
  parameter int UNIT_COUNTS_US = 10,
  parameter int CLK_MHZ        = 8,
  parameter int DELAY_BITS     = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  delay_enable_in,
  input  logic                  delay_start_strobe_in,
  input  logic [DELAY_BITS-1:0] delay_value_in,
  output logic                  delay_busy_out,
  output logic                  delay_done_out,
  output logic                  delay_abort_out
);

  localparam int PRESCALE = UNIT_COUNTS_US * CLK_MHZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]         PRESC_RELOAD = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]         PRESC_ONE    = PW'(1);
  localparam logic [DELAY_BITS-1:0] UNIT_ONE     = DELAY_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           presc, presc_nxt;
  logic [DELAY_BITS-1:0]   units, units_nxt;
  logic                    armed, armed_nxt;
  logic                    accept;
  logic                    abort;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    units_nxt = units;
    accept    = 1'b0;
    abort     = 1'b0;

    case (state)
      IDLE, DONE: begin
        // DONE lasts exactly one cycle but may start the next run directly.
        state_nxt = IDLE;
        if (delay_start_strobe_in && delay_enable_in && armed) begin
          accept    = 1'b1;
          state_nxt = COUNT;
          presc_nxt = PRESC_RELOAD;
          units_nxt = delay_value_in;
        end
      end
      COUNT: begin
        // Cancellation wins over expiry in the same cycle.
        if (!delay_enable_in) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if ((units == '0) || ((presc == '0) && (units == UNIT_ONE))) begin
          // Value 0 expires after one cycle; otherwise the last unit ran out.
          // Units are never decremented below 1, so no wrap-around.
          state_nxt = DONE;
        end else if (presc == '0) begin
          presc_nxt = PRESC_RELOAD;
          units_nxt = units - UNIT_ONE;
        end else begin
          presc_nxt = presc - PRESC_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (accept)
      armed_nxt = 1'b0;
    else if (!delay_start_strobe_in)
      armed_nxt = 1'b1;
    else
      armed_nxt = armed;
  end

  // Outputs are flopped from the next-state decode so they line up with state.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state           <= IDLE;
      presc           <= '0;
      units           <= '0;
      armed           <= 1'b0;
      delay_busy_out  <= 1'b0;
      delay_done_out  <= 1'b0;
      delay_abort_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      presc           <= presc_nxt;
      units           <= units_nxt;
      armed           <= armed_nxt;
      delay_busy_out  <= (state_nxt == COUNT);
      delay_done_out  <= (state_nxt == DONE);
      delay_abort_out <= abort;
    end
  end

endmodule
